mfp_spi_lcd_master: RTL and testbench

- AHB-Lite slave peripheral driving the SPI LCD pins (IO_SPI_SDO, IO_SPI_RS, IO_SPI_SCK).
- Sits downstream of the AHB fabric and its address decoder, which supplies HSEL.
- Buffers CPU-written command/data bytes in a small FIFO and serializes them MSB-first, SPI mode 0, with a programmable clock divider.
- Bus writes never stall: HREADY is always 1.

---
 rtl/mfp_spi_lcd_master_if.sv | 22 ++
 rtl/mfp_spi_lcd_master.sv | 190 +++++++++++++++++++
 tb/tb_mfp_spi_lcd_master.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/mfp_spi_lcd_master_if.sv
// AHB-Lite slave-side signal bundle for the SPI LCD master.
// The master modport is the bus/decoder side; the slave modport is the peripheral.
interface mfp_spi_lcd_master_if;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA;
   logic        HREADY;
   logic        HRESP;

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HWDATA,
      input  HRDATA, HREADY, HRESP
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HWDATA,
      output HRDATA, HREADY, HRESP
   );
endinterface

// File: rtl/mfp_spi_lcd_master.sv
// AHB-Lite SPI LCD master: CPU writes {RS, byte} into a TX FIFO and the FSM
// shifts each byte out MSB-first in SPI mode 0 with a programmable divider.
// Optional macro MFP_SPI_LCD_IRQ_EN adds the IE register at 0xC and the IRQ port.
//
// state | meaning
// IDLE  | waiting for the FIFO to hold a byte
// LOAD  | pop FIFO, latch RS/shift register/divider, present bit 7
// LOW   | SCK low for div+1 cycles
// HIGH  | SCK high for div+1 cycles; slave sampled on entry
// DONE  | one-cycle gap after bit 0, then next byte or idle
module mfp_spi_lcd_master #(
   parameter int          FIFO_DEPTH  = 8,
   parameter logic [15:0] DEFAULT_DIV = 16'd4
) (
   input  logic                     HCLK,
   input  logic                     HRESETn,
   mfp_spi_lcd_master_if.slave      ahb,
   output logic                     IO_SPI_SDO,
   output logic                     IO_SPI_SCK,
`ifdef MFP_SPI_LCD_IRQ_EN
   output logic                     IO_SPI_RS,
   output logic                     IRQ
`else
   output logic                     IO_SPI_RS
`endif
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_LOW, ST_HIGH, ST_DONE} state_t;

   state_t        state_q, state_d;
   logic          wr_q;
   logic [1:0]    addr_q;
   logic [31:0]   hrdata_q, rd_val;
   logic [8:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] count;
   logic          empty, full, push, pop, busy, ovf;
   logic [1:0]    level;
   logic [15:0]   clkdiv, div_latched, tmr;
   logic [7:0]    shreg;
   logic [2:0]    bitcnt;
   logic          rs_q, sck_q;
   logic          wr_data, wr_stat, wr_div;
   logic          ie;
   logic          unused_ok;

   assign unused_ok = ^{ahb.HADDR[31:4], ahb.HADDR[1:0], ahb.HWDATA[31:16]};

   assign empty   = (count == '0);
   assign full    = (count == CW'(FIFO_DEPTH));
   assign level   = (count >= CW'(3)) ? 2'd3 : count[1:0];
   assign busy    = (state_q != ST_IDLE);
   assign wr_data = wr_q && (addr_q == 2'd0);
   assign wr_stat = wr_q && (addr_q == 2'd1);
   assign wr_div  = wr_q && (addr_q == 2'd2);
   assign pop     = (state_q == ST_LOAD);
   // A full FIFO still accepts a write in the cycle LOAD frees a slot.
   assign push    = wr_data && (!full || pop);

   assign ahb.HRDATA = hrdata_q;
   assign ahb.HREADY = 1'b1;
   assign ahb.HRESP  = 1'b0;
   assign IO_SPI_SDO = shreg[7];
   assign IO_SPI_SCK = sck_q;
   assign IO_SPI_RS  = rs_q;

   // Read mux for the register addressed in the current address phase.
   always_comb begin
      rd_val = '0;
      case (ahb.HADDR[3:2])
         2'd1:    rd_val = {26'b0, ovf, busy, full, empty, level};
         2'd2:    rd_val = {16'b0, clkdiv};
         2'd3:    rd_val = {31'b0, ie};
         default: rd_val = '0;
      endcase
   end

   // Address-phase capture and registered read data.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_q     <= 1'b0;
         addr_q   <= 2'd0;
         hrdata_q <= '0;
      end else begin
         wr_q     <= ahb.HSEL && ahb.HTRANS[1] && ahb.HWRITE;
         addr_q   <= ahb.HADDR[3:2];
         hrdata_q <= (ahb.HSEL && ahb.HTRANS[1] && !ahb.HWRITE) ? rd_val : '0;
      end
   end

   // FIFO storage; contents are don't-care while the count says empty.
   always_ff @(posedge HCLK) begin
      if (push) mem[wr_ptr] <= ahb.HWDATA[8:0];
   end

   // FIFO pointers, occupancy and control registers.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf    <= 1'b0;
         clkdiv <= DEFAULT_DIV;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (wr_stat)                    ovf <= 1'b0;
         else if (wr_data && full && !pop) ovf <= 1'b1;
         if (wr_div) clkdiv <= ahb.HWDATA[15:0];
      end
   end

`ifdef MFP_SPI_LCD_IRQ_EN
   // Interrupt enable and registered "all drained" interrupt.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         ie  <= 1'b0;
         IRQ <= 1'b0;
      end else begin
         if (wr_q && (addr_q == 2'd3)) ie <= ahb.HWDATA[0];
         IRQ <= ie && empty && (state_q == ST_IDLE);
      end
   end
`else
   assign ie = 1'b0;
`endif

   // FSM state register.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // FSM next-state: half-period timer is a down-counter ending at zero.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (!empty) state_d = ST_LOAD;
         ST_LOAD: state_d = ST_LOW;
         ST_LOW:  if (tmr == 16'd0) state_d = ST_HIGH;
         ST_HIGH: if (tmr == 16'd0) state_d = (bitcnt == 3'd7) ? ST_DONE : ST_LOW;
         ST_DONE: state_d = empty ? ST_IDLE : ST_LOAD;
         default: state_d = ST_IDLE;
      endcase
   end

   // Shift datapath, timer and registered SCK.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         shreg       <= 8'h00;
         rs_q        <= 1'b0;
         sck_q       <= 1'b0;
         bitcnt      <= 3'd0;
         tmr         <= 16'd0;
         div_latched <= 16'd0;
      end else begin
         sck_q <= (state_d == ST_HIGH);
         case (state_q)
            ST_LOAD: begin
               {rs_q, shreg} <= mem[rd_ptr];
               div_latched   <= clkdiv;
               tmr           <= clkdiv;
               bitcnt        <= 3'd0;
            end
            ST_LOW: tmr <= (tmr == 16'd0) ? div_latched : tmr - 1'b1;
            ST_HIGH: begin
               if (tmr == 16'd0) begin
                  tmr <= div_latched;
                  if (bitcnt != 3'd7) begin
                     shreg  <= {shreg[6:0], 1'b0};
                     bitcnt <= bitcnt + 1'b1;
                  end
               end else begin
                  tmr <= tmr - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mfp_spi_lcd_master.sv
// Directed bench for mfp_spi_lcd_master. STATUS layout is
// {OVF, BUSY, FULL, EMPTY, LEVEL[1:0]}, so an idle, empty block reads 0x4.
module tb_mfp_spi_lcd_master;
   logic HCLK = 1'b0;
   logic HRESETn;
   logic sdo, sck, rs;
`ifdef MFP_SPI_LCD_IRQ_EN
   logic irq;
`endif

   mfp_spi_lcd_master_if ahb ();

   mfp_spi_lcd_master #(.FIFO_DEPTH(8), .DEFAULT_DIV(16'd4)) dut (
      .HCLK      (HCLK),
      .HRESETn   (HRESETn),
      .ahb       (ahb),
      .IO_SPI_SDO(sdo),
      .IO_SPI_SCK(sck),
`ifdef MFP_SPI_LCD_IRQ_EN
      .IO_SPI_RS (rs),
      .IRQ       (irq)
`else
      .IO_SPI_RS (rs)
`endif
   );

   always #5 HCLK = ~HCLK;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic bus_idle();
      ahb.HSEL = 1'b0; ahb.HTRANS = 2'b00; ahb.HWRITE = 1'b0;
      ahb.HADDR = 32'h0; ahb.HWDATA = 32'h0;
   endtask

   // All bus tasks start and end 1 time unit after a rising edge.
   task automatic ahb_write(input logic [31:0] a, input logic [31:0] d);
      ahb.HSEL = 1'b1; ahb.HTRANS = 2'b10; ahb.HWRITE = 1'b1; ahb.HADDR = a;
      @(posedge HCLK); #1;
      ahb.HSEL = 1'b0; ahb.HTRANS = 2'b00; ahb.HWRITE = 1'b0; ahb.HWDATA = d;
      @(posedge HCLK); #1;
   endtask

   task automatic ahb_read(input logic [31:0] a, output logic [31:0] d);
      ahb.HSEL = 1'b1; ahb.HTRANS = 2'b10; ahb.HWRITE = 1'b0; ahb.HADDR = a;
      @(posedge HCLK); #1;
      bus_idle();
      d = ahb.HRDATA;
   endtask

   task automatic ahb_burst_data(input int n, input logic [31:0] base);
      for (int i = 0; i <= n; i++) begin
         if (i < n) begin
            ahb.HSEL = 1'b1; ahb.HTRANS = 2'b10; ahb.HWRITE = 1'b1; ahb.HADDR = 32'h0;
         end else begin
            ahb.HSEL = 1'b0; ahb.HTRANS = 2'b00; ahb.HWRITE = 1'b0;
         end
         if (i > 0) ahb.HWDATA = base + 32'(i - 1);
         @(posedge HCLK); #1;
      end
      bus_idle();
   endtask

   task automatic do_reset();
      HRESETn = 1'b0;
      bus_idle();
      #12;
      HRESETn = 1'b1;
      @(posedge HCLK); #1;
   endtask

   logic [31:0] rd;
   logic        sck_prev;
   int          rise_c [16];
   logic        rise_d [16];
   logic        rise_rs[16];
   int          n_rise;
   logic [7:0]  byte_a, byte_b;

   initial begin
      HRESETn = 1'b0;
      bus_idle();
      #3;
      check("rst_sck", 32'(sck), 32'h0);
      check("rst_sdo", 32'(sdo), 32'h0);
      check("rst_rs", 32'(rs), 32'h0);
      check("rst_hrdata", ahb.HRDATA, 32'h0);
      check("hready", 32'(ahb.HREADY), 32'h1);
      check("hresp", 32'(ahb.HRESP), 32'h0);
      #10;
      HRESETn = 1'b1;
      @(posedge HCLK); #1;

      // Reset register values
      ahb_read(32'h4, rd);  check("rst_status", rd, 32'h4);
      ahb_read(32'h8, rd);  check("rst_clkdiv", rd, 32'h4);
      ahb_read(32'h0, rd);  check("data_read_zero", rd, 32'h0);
      ahb_read(32'hC, rd);  check("rsvd_read_zero", rd, 32'h0);

      // Single byte 0x1A5, DIV=4: rises at edges 8,18,...,78 after the data edge (edge 1)
      n_rise = 0;
      ahb_write(32'h0, 32'h1A5);
      sck_prev = sck;
      for (int c = 2; c <= 83; c++) begin
         @(posedge HCLK); #1;
         if (sck && !sck_prev && n_rise < 16) begin
            rise_c[n_rise] = c; rise_d[n_rise] = sdo; rise_rs[n_rise] = rs; n_rise++;
         end
         sck_prev = sck;
      end
      check("b1_nrise", 32'(n_rise), 32'd8);
      for (int k = 0; k < 8; k++) byte_a[7-k] = rise_d[k];
      check("b1_bits", 32'(byte_a), 32'hA5);
      check("b1_rs", 32'(rise_rs[0]), 32'h1);
      check("b1_first_rise", 32'(rise_c[0]), 32'd8);
      check("b1_spacing", 32'(rise_c[7] - rise_c[0]), 32'd70);
      ahb_read(32'h4, rd);  check("b1_busy_in_done", rd, 32'h14);
      ahb_read(32'h4, rd);  check("b1_busy_clear", rd, 32'h04);
      check("b1_sdo_hold", 32'(sdo), 32'h1);
      check("b1_rs_hold", 32'(rs), 32'h1);

      // FIFO fill with a slow divider
      ahb_write(32'h8, 32'hFFFF);
      ahb_read(32'h8, rd);  check("div_ffff", rd, 32'hFFFF);
      ahb_burst_data(9, 32'h100);
      ahb_read(32'h4, rd);  check("fill9_status", rd, 32'h1B);
      ahb_write(32'h0, 32'h1AA);
      ahb_read(32'h4, rd);  check("ovf_set", rd, 32'h3B);
      ahb_write(32'h4, 32'h0);
      ahb_read(32'h4, rd);  check("ovf_clear", rd, 32'h1B);

      // Divider change mid-byte: first byte at 10-cycle period, second at 2
      do_reset();
      n_rise = 0;
      ahb_write(32'h0, 32'h0F0);
      ahb_write(32'h0, 32'h13C);
      ahb_write(32'h8, 32'h0);
      sck_prev = sck;
      for (int c = 0; c < 200; c++) begin
         @(posedge HCLK); #1;
         if (sck && !sck_prev && n_rise < 16) begin
            rise_c[n_rise] = c; rise_d[n_rise] = sdo; rise_rs[n_rise] = rs; n_rise++;
         end
         sck_prev = sck;
      end
      check("dv_nrise", 32'(n_rise), 32'd16);
      for (int k = 0; k < 8; k++) begin
         byte_a[7-k] = rise_d[k];
         byte_b[7-k] = rise_d[k+8];
      end
      check("dv_byte_a", 32'(byte_a), 32'hF0);
      check("dv_byte_b", 32'(byte_b), 32'h3C);
      check("dv_rs_a", 32'(rise_rs[0]), 32'h0);
      check("dv_rs_b", 32'(rise_rs[8]), 32'h1);
      check("dv_old_period_first", 32'(rise_c[1] - rise_c[0]), 32'd10);
      check("dv_old_period_last", 32'(rise_c[7] - rise_c[6]), 32'd10);
      check("dv_byte_gap", 32'(rise_c[8] - rise_c[7]), 32'd8);
      check("dv_new_period_first", 32'(rise_c[9] - rise_c[8]), 32'd2);
      check("dv_new_period_last", 32'(rise_c[15] - rise_c[14]), 32'd2);

      // Asynchronous reset in the HIGH phase of bit 3 with bytes queued
      do_reset();
      n_rise = 0;
      ahb_write(32'h0, 32'h0FF);
      ahb_write(32'h0, 32'h011);
      ahb_write(32'h0, 32'h022);
      sck_prev = sck;
      for (int c = 0; c < 100 && n_rise < 4; c++) begin
         @(posedge HCLK); #1;
         if (sck && !sck_prev) n_rise++;
         sck_prev = sck;
      end
      check("ar_reached_bit3", 32'(n_rise), 32'd4);
      @(posedge HCLK); #1;
      check("ar_sck_high", 32'(sck), 32'h1);
      HRESETn = 1'b0;
      #1;
      check("ar_sck_drop", 32'(sck), 32'h0);
      check("ar_sdo_drop", 32'(sdo), 32'h0);
      #1;
      HRESETn = 1'b1;
      @(posedge HCLK); #1;
      n_rise = 0;
      sck_prev = sck;
      for (int c = 0; c < 60; c++) begin
         @(posedge HCLK); #1;
         if (sck && !sck_prev) n_rise++;
         sck_prev = sck;
      end
      check("ar_no_edges", 32'(n_rise), 32'd0);
      ahb_read(32'h4, rd);  check("ar_status", rd, 32'h4);
      ahb_read(32'h8, rd);  check("ar_clkdiv", rd, 32'h4);

`ifdef MFP_SPI_LCD_IRQ_EN
      check("irq_off", 32'(irq), 32'h0);
      ahb_write(32'hC, 32'h1);
      ahb_read(32'hC, rd);  check("ie_read", rd, 32'h1);
      check("irq_idle_on", 32'(irq), 32'h1);
      ahb_write(32'h0, 32'h055);
      for (int c = 2; c <= 85; c++) begin
         @(posedge HCLK); #1;
         if (c == 2)  check("irq_busy_low", 32'(irq), 32'h0);
         if (c == 84) check("irq_done_low", 32'(irq), 32'h0);
         if (c == 85) check("irq_rise", 32'(irq), 32'h1);
      end
`else
      ahb_write(32'hC, 32'h1);
      ahb_read(32'hC, rd);  check("rsvd_write_ignored", rd, 32'h0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
